truth_table_checker: RTL and testbench
======================================

# truth_table_checker

Parametrised, self-checking truth-table sweeper for an N-input, single-output combinational function. On `start` it drives every one of the 2^N input combinations onto `vec`, in binary or Gray order, holding each for `SETTLE` cycles. It compares the function's output against a latched expected minterm mask and reports a mismatch count, the first failing vector and an overall pass flag. It replaces hand-written per-vector stimulus/monitor sequences in the truth-table exercises: one instance per function under test (SoP or PoS form), with the function wired combinationally from `vec` to `dut_out`.

## Interface
- `N`, default 2: number of function inputs, 1..8.
- `SETTLE`, default 1: cycles each vector is held, ≥1. `dut_out` is sampled in the last hold cycle.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: begin a sweep. Accepted in IDLE or DONE only.
- `gray`, input, 1: order select, latched at accepted `start`. 0 = binary, 1 = reflected Gray.
- `expect`, input, 2^N: expected minterm mask, latched at accepted `start`. Bit i is the expected output for `vec == i`.
- `dut_out`, input, 1: output of the function under test.
- `vec`, output, N: applied input vector. `vec[N-1]` is the first/MSB variable (x), `vec[0]` the last (y).
- `busy`, output, 1: high in RUN.
- `done`, output, 1: high in DONE.
- `pass`, output, 1: `done && err_count == 0`.
- `err_count`, output, N+1: number of mismatching vectors, 0..2^N.
- `fail_valid`, output, 1: at least one mismatch captured this sweep.
- `first_fail`, output, N: `vec` value of the first mismatch.

## Operation
- States:
  - IDLE: `vec` = 0, `busy` = 0, `done` = 0.
  - RUN.
  - DONE: `vec` = 0, `done` = 1; results are held.
- Transitions:
  - IDLE → RUN on `start`.
  - RUN → DONE after the compare of the 2^N-th vector.
  - DONE → RUN on `start`.
  - Any state → IDLE on `reset`.
- Accepted `start` does the following:
  - clears `err_count`, `fail_valid` and `first_fail`;
  - latches `expect` and `gray`;
  - resets index `idx` and hold counter `h` to 0.
- In RUN:
  - `vec = gray_l ? idx ^ (idx >> 1) : idx`.
  - `h` counts 0..SETTLE-1.
  - When `h == SETTLE-1`, compare `dut_out` against `expect_l[vec]`, using the applied vector, not `idx`, as the index. Then `idx` increments and `h` returns to 0.
- Mismatch rule: `dut_out !== expect_l[vec]`, so X/Z on `dut_out` counts as a mismatch.
- On a mismatch:
  - `err_count` increments; it cannot overflow, because N+1 bits hold 2^N.
  - If `fail_valid` is 0, `first_fail` ← `vec` and `fail_valid` ← 1.
- `idx` is N+1 bits wide so the terminal count 2^N is detectable. `vec` uses the low N bits only.
- `start` during RUN is ignored: no restart and no relatch.
- Changes to `expect`/`gray` outside an accepted `start` have no effect.
- `reset` mid-sweep aborts immediately. The next cycle shows IDLE with all outputs at their reset values.

## Timing
- Reset values: `vec` = 0, `busy` = 0, `done` = 0, `pass` = 0, `err_count` = 0, `fail_valid` = 0, `first_fail` = 0. State = IDLE.
- `start` sampled high at edge T:
  - `busy` = 1 and `vec` = first vector (0) from T+1.
  - Vector k is applied during cycles T+1+k·SETTLE .. T+(k+1)·SETTLE.
  - Sample point is the final cycle of each hold window.
- `done` rises at T+1+2^N·SETTLE; `busy` falls in the same cycle.
- `err_count`/`first_fail` update one cycle after the sample edge and are stable in DONE.
- `pass` is combinational from state and `err_count`, and is valid only while `done`.
- `start` and `reset` together: `reset` wins.
- `start` in the same cycle as the RUN→DONE transition: ignored. FSM enters DONE, and a later `start` is required.

## Test plan
- **Correct function, binary order.** N=2, SETTLE=1, `expect`=4'b0100, `dut_out = vec[1] & ~vec[0]` (~y·x), `start` at T → `vec` 00,01,10,11 at T+1..T+4; `done` at T+5, `pass`=1, `err_count`=0, `fail_valid`=0.
- **Wrong function, mismatches counted.** N=2, `expect`=4'b1110 (x+y), `dut_out = vec[1]&vec[0]` → `err_count`=2, `first_fail`=2'b01, `fail_valid`=1, `pass`=0.
- **Gray order with settle and X input.**
  - N=3, SETTLE=3, `gray`=1, `expect`=8'hFF, `dut_out`=1 → `vec` sequence 000,001,011,010,110,111,101,100, each held 3 cycles; `done` at T+25, `pass`=1.
  - Same setup with `dut_out`=X on one vector → `err_count`=1.
- **Reset mid-sweep.** `reset` asserted for 1 cycle at T+2 of an N=2 sweep → next cycle IDLE, all outputs 0. A fresh `start` completes normally.
- **Ignored start, relatch on restart.**
  - `start` pulsed at T+2 during RUN, and `expect` changed mid-run → no restart; result uses the `expect` latched at T.
  - `start` in DONE → counters cleared and sweep reruns.
- **Maximum width.** N=8, `expect`=all-ones, `dut_out`=0 → `err_count`=256, `first_fail`=0, `done` at T+1+256·SETTLE.

Source files
------------

// File: rtl/truth_table_checker.sv
// truth_table_checker
//   Sweeps all 2^N input combinations of a combinational function under test,
//   in binary or reflected-Gray order, holding each vector SETTLE cycles and
//   comparing the function output against a latched expected minterm mask.
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-high
//   start        begin a sweep (accepted in IDLE or DONE only)
//   gray         order select latched at accepted start (1 = reflected Gray)
//   expect_mask  expected minterm mask latched at accepted start; bit i is the
//                expected output for vec == i
//   dut_out      output of the function under test
//   vec          applied input vector, vec[N-1] is the first/MSB variable
//   busy         sweep in progress
//   done         sweep finished, results held
//   pass         done with no mismatches
//   err_count    number of mismatching vectors (0..2^N)
//   fail_valid   at least one mismatch captured this sweep
//   first_fail   vector of the first mismatch
//
// state  | meaning
// S_IDLE | after reset, vec = 0, waiting for start
// S_RUN  | applying vectors and comparing at the end of each hold window
// S_DONE | sweep complete, vec = 0, results held until next start

module truth_table_checker #(
  parameter int N      = 2,
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                gray,
  input  logic [(1<<N)-1:0]   expect_mask,
  input  logic                dut_out,
  output logic [N-1:0]        vec,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N:0]          err_count,
  output logic                fail_valid,
  output logic [N-1:0]        first_fail
);

  localparam int              HW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [HW-1:0]   H_LAST   = HW'(SETTLE - 1);
  localparam logic [N:0]      IDX_LAST = {1'b0, {N{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [N:0]          idx_q;
  logic [HW-1:0]       h_q;
  logic                gray_l;
  logic [(1<<N)-1:0]   expect_l;

  logic                start_ok;
  logic                sample;
  logic                last;
  logic                mismatch;
  logic [N-1:0]        run_vec;

  assign start_ok = start && (state_q != S_RUN);

  // idx never exceeds 2^N-1 while a compare is pending, so the low N bits
  // are sufficient for the Gray conversion.
  assign run_vec  = gray_l ? (idx_q[N-1:0] ^ (idx_q[N-1:0] >> 1)) : idx_q[N-1:0];
  assign sample   = (state_q == S_RUN) && (h_q == H_LAST);
  assign last     = sample && (idx_q == IDX_LAST);

  // Case inequality so an X/Z on dut_out is reported as a mismatch.
  assign mismatch = sample && (dut_out !== expect_l[run_vec]);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    vec  = '0;
    case (state_q)
      S_RUN: begin
        busy = 1'b1;
        vec  = run_vec;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign pass = done && (err_count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q      <= '0;
      h_q        <= '0;
      gray_l     <= 1'b0;
      expect_l   <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
    end else if (start_ok) begin
      idx_q      <= '0;
      h_q        <= '0;
      gray_l     <= gray;
      expect_l   <= expect_mask;
      err_count  <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
    end else if (state_q == S_RUN) begin
      if (sample) begin
        h_q   <= '0;
        idx_q <= idx_q + (N+1)'(1);
        if (mismatch) begin
          err_count <= err_count + (N+1)'(1);
          if (!fail_valid) begin
            first_fail <= run_vec;
            fail_valid <= 1'b1;
          end
        end
      end else begin
        h_q <= h_q + HW'(1);
      end
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: three instances (N=2/SETTLE=1,
// N=3/SETTLE=3, N=8/SETTLE=1) exercised one at a time through a shared
// stimulus task. Expected vector sequence is queued at start and popped
// each cycle; final results come from a reference model.

module tb_truth_table_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start;
  logic         gray;
  logic [255:0] mask_in;
  int           sel;
  int           mode;
  logic         inject;
  logic [7:0]   xv;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] vec2, ff2;
  logic [2:0] err2;
  logic       busy2, done2, pass2, fv2, dut2;

  logic [2:0] vec3, ff3;
  logic [3:0] err3;
  logic       busy3, done3, pass3, fv3, dut3;

  logic [7:0] vec8, ff8;
  logic [8:0] err8;
  logic       busy8, done8, pass8, fv8, dut8;

  assign dut2 = mode ? (vec2[1] & vec2[0]) : (vec2[1] & ~vec2[0]);
  assign dut3 = (inject && vec3 == xv[2:0]) ? 1'bx : 1'b1;
  assign dut8 = 1'b0;

  truth_table_checker #(.N(2), .SETTLE(1)) u2 (
    .clk(clk), .reset(reset), .start(start && sel == 0), .gray(gray),
    .expect_mask(mask_in[3:0]), .dut_out(dut2), .vec(vec2), .busy(busy2),
    .done(done2), .pass(pass2), .err_count(err2), .fail_valid(fv2),
    .first_fail(ff2));

  truth_table_checker #(.N(3), .SETTLE(3)) u3 (
    .clk(clk), .reset(reset), .start(start && sel == 1), .gray(gray),
    .expect_mask(mask_in[7:0]), .dut_out(dut3), .vec(vec3), .busy(busy3),
    .done(done3), .pass(pass3), .err_count(err3), .fail_valid(fv3),
    .first_fail(ff3));

  truth_table_checker #(.N(8), .SETTLE(1)) u8 (
    .clk(clk), .reset(reset), .start(start && sel == 2), .gray(gray),
    .expect_mask(mask_in), .dut_out(dut8), .vec(vec8), .busy(busy8),
    .done(done8), .pass(pass8), .err_count(err8), .fail_valid(fv8),
    .first_fail(ff8));

  logic [31:0] o_vec, o_err, o_ff;
  logic        o_busy, o_done, o_pass, o_fv;

  always_comb begin
    o_vec = '0; o_err = '0; o_ff = '0;
    o_busy = 1'b0; o_done = 1'b0; o_pass = 1'b0; o_fv = 1'b0;
    case (sel)
      0: begin
        o_vec = 32'(vec2); o_err = 32'(err2); o_ff = 32'(ff2);
        o_busy = busy2; o_done = done2; o_pass = pass2; o_fv = fv2;
      end
      1: begin
        o_vec = 32'(vec3); o_err = 32'(err3); o_ff = 32'(ff3);
        o_busy = busy3; o_done = done3; o_pass = pass3; o_fv = fv3;
      end
      default: begin
        o_vec = 32'(vec8); o_err = 32'(err8); o_ff = 32'(ff8);
        o_busy = busy8; o_done = done8; o_pass = pass8; o_fv = fv8;
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (inst %0d): observed %0h expected %0h", tag, sel, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " vec"},   o_vec, 0);
    check({tag, " busy"},  32'(o_busy), 0);
    check({tag, " done"},  32'(o_done), 0);
    check({tag, " pass"},  32'(o_pass), 0);
    check({tag, " err"},   o_err, 0);
    check({tag, " fv"},    32'(o_fv), 0);
    check({tag, " ff"},    o_ff, 0);
  endtask

  function automatic logic model_mis(input int s, input logic [7:0] v, input logic [255:0] m);
    logic o;
    case (s)
      0: o = mode ? (v[1] & v[0]) : (v[1] & ~v[0]);
      1: begin
        if (inject && v[2:0] == xv[2:0]) return 1'b1;
        o = 1'b1;
      end
      default: o = 1'b0;
    endcase
    return o != m[v];
  endfunction

  // One sweep on instance s. poke_k: loop cycle at which start is pulsed and
  // mask/gray are changed to m2/g2 (-1 = never). rst_k: loop cycle at which
  // reset is pulsed, aborting the sweep (-1 = never).
  task automatic sweep(input int s, input logic [255:0] m, input logic g,
                       input int poke_k, input logic [255:0] m2, input logic g2,
                       input int rst_k);
    int         nb, st, total, k, exp_err;
    logic [7:0] v, exp_ff;
    logic       exp_fv;
    logic [7:0] vq[$];
    sel     = s;
    nb      = (s == 0) ? 2 : (s == 1) ? 3 : 8;
    st      = (s == 1) ? 3 : 1;
    total   = 1 << nb;
    exp_err = 0;
    exp_ff  = '0;
    exp_fv  = 1'b0;
    mask_in = m;
    gray    = g;
    start   = 1'b1;
    for (int i = 0; i < total; i++) begin
      v = 8'(i);
      if (g) v = v ^ (v >> 1);
      for (int j = 0; j < st; j++) vq.push_back(v);
      if (model_mis(s, v, m)) begin
        exp_err++;
        if (!exp_fv) begin exp_ff = v; exp_fv = 1'b1; end
      end
    end
    @(negedge clk);
    k = 0;
    while (vq.size() > 0) begin
      v = vq.pop_front();
      check("busy", 32'(o_busy), 1);
      check("vec",  o_vec, 32'(v));
      if (k == 0) begin
        check("err cleared", o_err, 0);
        check("fv cleared",  32'(o_fv), 0);
        check("done low",    32'(o_done), 0);
      end
      start = 1'b0;
      if (k == poke_k) begin
        start   = 1'b1;
        mask_in = m2;
        gray    = g2;
      end
      if (k == rst_k) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle("after reset");
        return;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check("done",       32'(o_done), 1);
    check("busy end",   32'(o_busy), 0);
    check("vec end",    o_vec, 0);
    check("err_count",  o_err, 32'(exp_err));
    check("fail_valid", 32'(o_fv), 32'(exp_fv));
    check("first_fail", o_ff, 32'(exp_ff));
    check("pass",       32'(o_pass), (exp_err == 0) ? 1 : 0);
    @(negedge clk);
    check("done hold",  32'(o_done), 1);
    check("busy hold",  32'(o_busy), 0);
    check("err hold",   o_err, 32'(exp_err));
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    gray    = 1'b0;
    mask_in = '0;
    sel     = 0;
    mode    = 0;
    inject  = 1'b0;
    xv      = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      check_idle("reset state");
    end
    reset = 1'b0;
    @(negedge clk);

    // correct function x & ~y, binary
    mode = 0;
    sweep(0, 256'h4, 1'b0, -1, '0, 1'b0, -1);
    // wrong function x & y against x + y, restarted from DONE
    mode = 1;
    sweep(0, 256'hE, 1'b0, -1, '0, 1'b0, -1);
    // start and new mask/gray mid-run are ignored
    mode = 0;
    sweep(0, 256'h4, 1'b0, 1, 256'hF, 1'b1, -1);
    // start coincident with RUN->DONE is ignored
    mode = 1;
    sweep(0, 256'hE, 1'b1, 3, 256'hE, 1'b1, -1);
    // reset mid-sweep, then a fresh sweep
    mode = 0;
    sweep(0, 256'h4, 1'b0, -1, '0, 1'b0, 1);
    sweep(0, 256'h4, 1'b0, -1, '0, 1'b0, -1);

    // Gray order, SETTLE=3, constant-1 function
    inject = 1'b0;
    sweep(1, 256'hFF, 1'b1, -1, '0, 1'b0, -1);
    // X on one vector counts as a mismatch
    inject = 1'b1;
    xv     = 8'h03;
    sweep(1, 256'hFF, 1'b1, -1, '0, 1'b0, -1);
    inject = 1'b0;

    // maximum width, every vector wrong
    sweep(2, {256{1'b1}}, 1'b0, -1, '0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
